l1_metadata_array_param: RTL and testbench
==========================================

Name: l1_metadata_array_param

Overview:
- Parametrised L1 data-cache tag/coherence metadata array: NSETS x NWAYS entries of {coh_state, tag}.
- Zero-initialises all sets after reset, then serves one read or one way-masked write per cycle.
- Adds over the fixed-size predecessor: invalidate-all (flush) sweep, registered response with valid, init-done status.
- Sits between the DCache pipeline/MSHR writeback logic and a synchronous 1R1W SRAM macro.

Parameters:
- NSETS, 64, number of sets; power of two, >=2.
- NWAYS, 8, associativity; width of way mask.
- TAG_BITS, 21, tag field width.
- COH_BITS, 2, coherence state width.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  reset; synchronous, active-low.
- io_read_ready  out  1  read accepted when high.
- io_read_valid  in  1  read request.
- io_read_bits_idx  in  log2(NSETS)  set index.
- io_write_ready  out  1  write accepted when high.
- io_write_valid  in  1  write request.
- io_write_bits_idx  in  log2(NSETS)  set index.
- io_write_bits_way_en  in  NWAYS  per-way write mask.
- io_write_bits_data_coh_state  in  COH_BITS  state written to enabled ways.
- io_write_bits_data_tag  in  TAG_BITS  tag written to enabled ways.
- io_flush_valid  in  1  invalidate-all request.
- io_flush_ready  out  1  flush accepted when high.
- io_resp_valid  out  1  response valid, one cycle after read fire.
- io_resp_coh_state  out  NWAYS*COH_BITS  way w at [w*COH_BITS +: COH_BITS].
- io_resp_tag  out  NWAYS*TAG_BITS  way w at [w*TAG_BITS +: TAG_BITS].
- io_init_done  out  1  high in RUN state.

Behaviour:
- FSM states SWEEP, RUN. reset_n low -> SWEEP, sweep counter 0, resp_valid 0, resp data registers 0.
- Reset mid-sweep or mid-flush restarts the sweep at set 0.
- SWEEP: each cycle writes all ways (mask all ones) at set = counter with coh_state 0, tag 0; counter increments.
- SWEEP: after writing set NSETS-1, next state is RUN; sweep lasts exactly NSETS cycles.
- SWEEP: io_read_ready, io_write_ready, io_flush_ready and io_init_done are all 0.
- RUN, ready signals:
  - io_write_ready = 1.
  - io_read_ready = ~io_write_valid (write has priority; no same-cycle read).
  - io_flush_ready = ~io_write_valid.
- Write fire: SRAM written this cycle at write idx, masked by way_en. Unmasked ways keep their contents.
- way_en = 0: legal; nothing changes.
- Flush fire: counter cleared, next state SWEEP. A read firing in the same cycle still completes normally.
- Read fire in cycle N: SRAM read enable in N; io_resp_valid=1 and data in N+1.
- No read fire in cycle N: io_resp_valid=0 in N+1 and resp data holds the last value (captured register, not raw SRAM output).
- Read in N+1 of a set written in N returns the new data; no forwarding needed, since write and read never share a cycle.
- Back-to-back reads: one response per cycle; no backpressure on response.

Decomposition:
- Package l1_meta_pkg: coh_state enum (NOTHING=0, BRANCH=1, TRUNK=2, DIRTY=3); l1_meta_t struct {coh_state, tag}; FSM state enum; localparams IDX_BITS=$clog2(NSETS) and ENTRY_BITS=COH_BITS+TAG_BITS.
- Sub-module l1_meta_sram: behavioural NSETS x (NWAYS*ENTRY_BITS) 1R1W sync memory with per-way write mask; swapped for the macro at integration.

Test Plan:
- Reset release, NSETS=64: io_init_done rises exactly 64 cycles after reset_n goes high; then a read of every set returns all coh=0, tag=0.
- Write idx=5, way_en=0x04, coh=3, tag=0x1ABCD; read idx=5 next cycle -> way2 {3,0x1ABCD}, other ways 0; resp_valid exactly one cycle after read fire.
- io_read_valid and io_write_valid together for 3 cycles -> read_ready=0 throughout, 3 writes land; read fires on the 4th cycle.
- Fill sets 0..63 with nonzero values, then pulse flush -> init_done low for 64 cycles, ready signals 0; all reads afterwards return zeros.
- Assert reset_n low at sweep counter=30 for one cycle -> sweep restarts at 0; init_done rises 64 cycles after release.
- Read idx=7, then 4 idle cycles -> resp_valid pulses for one cycle; resp data stays at set 7 contents throughout.

Source files
------------

// File: rtl/l1_metadata_array_param_pkg.sv
// Shared types and default sizing for the L1 data-cache metadata array.
package l1_meta_pkg;

  localparam int unsigned NSETS_DEF    = 64;
  localparam int unsigned NWAYS_DEF    = 8;
  localparam int unsigned TAG_BITS_DEF = 21;
  localparam int unsigned COH_BITS_DEF = 2;
  localparam int unsigned IDX_BITS     = $clog2(NSETS_DEF);
  localparam int unsigned ENTRY_BITS   = COH_BITS_DEF + TAG_BITS_DEF;

  typedef enum logic [COH_BITS_DEF-1:0] {
    NOTHING = 2'd0,
    BRANCH  = 2'd1,
    TRUNK   = 2'd2,
    DIRTY   = 2'd3
  } coh_state_e;

  typedef struct packed {
    coh_state_e              coh_state;
    logic [TAG_BITS_DEF-1:0] tag;
  } l1_meta_t;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } meta_fsm_e;

endpackage

// File: rtl/l1_metadata_array_param_if.sv
// Pipeline/MSHR-facing request, response and status bundle of the metadata array.
interface l1_metadata_array_param_if #(
  parameter int unsigned NSETS    = 64,
  parameter int unsigned NWAYS    = 8,
  parameter int unsigned TAG_BITS = 21,
  parameter int unsigned COH_BITS = 2
);
  localparam int unsigned IDX_W = $clog2(NSETS);

  logic                      read_ready;
  logic                      read_valid;
  logic [IDX_W-1:0]          read_bits_idx;
  logic                      write_ready;
  logic                      write_valid;
  logic [IDX_W-1:0]          write_bits_idx;
  logic [NWAYS-1:0]          write_bits_way_en;
  logic [COH_BITS-1:0]       write_bits_data_coh_state;
  logic [TAG_BITS-1:0]       write_bits_data_tag;
  logic                      flush_valid;
  logic                      flush_ready;
  logic                      resp_valid;
  logic [NWAYS*COH_BITS-1:0] resp_coh_state;
  logic [NWAYS*TAG_BITS-1:0] resp_tag;
  logic                      init_done;

  modport master (
    output read_valid, read_bits_idx,
    output write_valid, write_bits_idx, write_bits_way_en,
    output write_bits_data_coh_state, write_bits_data_tag,
    output flush_valid,
    input  read_ready, write_ready, flush_ready,
    input  resp_valid, resp_coh_state, resp_tag, init_done
  );

  modport slave (
    input  read_valid, read_bits_idx,
    input  write_valid, write_bits_idx, write_bits_way_en,
    input  write_bits_data_coh_state, write_bits_data_tag,
    input  flush_valid,
    output read_ready, write_ready, flush_ready,
    output resp_valid, resp_coh_state, resp_tag, init_done
  );

endinterface

// File: rtl/l1_metadata_array_param_sram.sv
// Behavioural 1R1W synchronous metadata SRAM with per-way write mask.
// Read data register only loads on a read, so it holds between reads.
module l1_meta_sram #(
  parameter int unsigned NSETS   = 64,
  parameter int unsigned NWAYS   = 8,
  parameter int unsigned ENTRY_W = 23
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       we,
  input  logic [$clog2(NSETS)-1:0]   widx,
  input  logic [NWAYS-1:0]           wmask,
  input  logic [NWAYS*ENTRY_W-1:0]   wdata,
  input  logic                       re,
  input  logic [$clog2(NSETS)-1:0]   ridx,
  output logic [NWAYS*ENTRY_W-1:0]   rdata
);

  logic [NWAYS-1:0][ENTRY_W-1:0] mem [NSETS];

  // Masked write: unselected ways keep their contents.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int w = 0; w < int'(NWAYS); w++) begin
        if (wmask[w]) mem[widx][w] <= wdata[w*ENTRY_W +: ENTRY_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) rdata <= '0;
    else if (re)  rdata <= mem[ridx];
  end

endmodule

// File: rtl/l1_metadata_array_param.sv
// L1 DCache tag/coherence metadata array: zeroing sweep after reset or flush,
// then one read or one way-masked write per cycle with a registered response.
module l1_metadata_array_param
  import l1_meta_pkg::*;
#(
  parameter int unsigned NSETS    = 64,
  parameter int unsigned NWAYS    = 8,
  parameter int unsigned TAG_BITS = 21,
  parameter int unsigned COH_BITS = 2
) (
  input  logic                        clock,
  input  logic                        reset_n,
  l1_metadata_array_param_if.slave    io
);

  localparam int unsigned IDX_W   = $clog2(NSETS);
  localparam int unsigned ENTRY_W = COH_BITS + TAG_BITS;
  localparam int unsigned ROW_W   = NWAYS * ENTRY_W;

  meta_fsm_e          state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               run;
  logic               read_fire, write_fire, flush_fire;
  logic               sram_we;
  logic [IDX_W-1:0]   sram_widx;
  logic [NWAYS-1:0]   sram_wmask;
  logic [ENTRY_W-1:0] wentry;
  logic [ROW_W-1:0]   sram_rdata;

  assign run            = (state_q == RUN);
  assign io.write_ready = run;
  assign io.read_ready  = run & ~io.write_valid;
  assign io.flush_ready = run & ~io.write_valid;
  assign io.init_done   = run;

  assign read_fire  = io.read_valid  & io.read_ready;
  assign write_fire = io.write_valid & io.write_ready;
  assign flush_fire = io.flush_valid & io.flush_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep walks every set once; a flush restarts it from set 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SWEEP: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(NSETS - 1)) state_d = RUN;
      end
      RUN: begin
        if (flush_fire) begin
          cnt_d   = '0;
          state_d = SWEEP;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  // Sweep owns the write port; otherwise it carries the pipeline write.
  assign sram_we    = ~run | write_fire;
  assign sram_widx  = run ? io.write_bits_idx : cnt_q;
  assign sram_wmask = run ? io.write_bits_way_en : '1;
  assign wentry     = run ? {io.write_bits_data_coh_state, io.write_bits_data_tag} : '0;

  l1_meta_sram #(
    .NSETS   (NSETS),
    .NWAYS   (NWAYS),
    .ENTRY_W (ENTRY_W)
  ) u_sram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (sram_we),
    .widx    (sram_widx),
    .wmask   (sram_wmask),
    .wdata   ({NWAYS{wentry}}),
    .re      (read_fire),
    .ridx    (io.read_bits_idx),
    .rdata   (sram_rdata)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) io.resp_valid <= 1'b0;
    else          io.resp_valid <= read_fire;
  end

  // Split each stored {coh_state, tag} entry into the per-field response buses.
  always_comb begin
    io.resp_coh_state = '0;
    io.resp_tag       = '0;
    for (int w = 0; w < int'(NWAYS); w++) begin
      io.resp_coh_state[w*COH_BITS +: COH_BITS] = sram_rdata[w*ENTRY_W + TAG_BITS +: COH_BITS];
      io.resp_tag[w*TAG_BITS +: TAG_BITS]       = sram_rdata[w*ENTRY_W +: TAG_BITS];
    end
  end

endmodule

// File: tb/tb_l1_metadata_array_param.sv
// Randomised scoreboard bench for l1_metadata_array_param against an array model.
module tb_l1_metadata_array_param;

  localparam int NSETS    = 64;
  localparam int NWAYS    = 8;
  localparam int TAG_BITS = 21;
  localparam int COH_BITS = 2;
  localparam int IDX_W    = 6;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  l1_metadata_array_param_if #(.NSETS(NSETS), .NWAYS(NWAYS), .TAG_BITS(TAG_BITS), .COH_BITS(COH_BITS)) io ();

  l1_metadata_array_param #(.NSETS(NSETS), .NWAYS(NWAYS), .TAG_BITS(TAG_BITS), .COH_BITS(COH_BITS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (io)
  );

  typedef struct {
    int                        due;
    logic [NWAYS*COH_BITS-1:0] coh;
    logic [NWAYS*TAG_BITS-1:0] tag;
  } exp_t;

  logic [COH_BITS-1:0] m_coh [NSETS][NWAYS];
  logic [TAG_BITS-1:0] m_tag [NSETS][NWAYS];
  exp_t q[$];
  exp_t e;
  logic [NWAYS*COH_BITS-1:0] last_coh = '0;
  logic [NWAYS*TAG_BITS-1:0] last_tag = '0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit in_run = 1'b0;
  bit mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(string nm, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void model_zero();
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < NWAYS; w++) begin
        m_coh[s][w] = '0;
        m_tag[s][w] = '0;
      end
  endfunction

  function automatic exp_t model_row(int idx, int due);
    exp_t r;
    r.due = due;
    r.coh = '0;
    r.tag = '0;
    for (int w = 0; w < NWAYS; w++) begin
      r.coh[w*COH_BITS +: COH_BITS] = m_coh[idx][w];
      r.tag[w*TAG_BITS +: TAG_BITS] = m_tag[idx][w];
    end
    return r;
  endfunction

  // Monitor: every response must match the oldest expected entry in the cycle it is due;
  // between responses the data must stay at the last delivered value.
  always @(posedge clock) begin
    #1;
    if (mon_en) begin
      if (io.resp_valid) begin
        if (q.size() == 0) check("resp_unexpected", 256'(io.resp_valid), 256'(0));
        else begin
          e = q.pop_front();
          check("resp_cycle", 256'(cyc), 256'(e.due));
          check("resp_coh", 256'(io.resp_coh_state), 256'(e.coh));
          check("resp_tag", 256'(io.resp_tag), 256'(e.tag));
          last_coh = e.coh;
          last_tag = e.tag;
        end
      end else begin
        if (q.size() != 0 && q[0].due <= cyc) begin
          check("resp_missing", 256'(io.resp_valid), 256'(1));
          e = q.pop_front();
          last_coh = e.coh;
          last_tag = e.tag;
        end
        check("hold_coh", 256'(io.resp_coh_state), 256'(last_coh));
        check("hold_tag", 256'(io.resp_tag), 256'(last_tag));
      end
    end
  end

  // Count edges until init_done, junk requests held the whole time must all be refused.
  task automatic wait_init(string nm);
    int n = 0;
    bit bad = 1'b0;
    while (!io.init_done && n < 200) begin
      io.read_valid        = 1'b1;
      io.read_bits_idx     = IDX_W'($urandom_range(0, NSETS-1));
      io.write_valid       = 1'($urandom_range(0, 1));
      io.write_bits_idx    = IDX_W'($urandom_range(0, NSETS-1));
      io.write_bits_way_en = '1;
      io.write_bits_data_coh_state = 2'd3;
      io.write_bits_data_tag = TAG_BITS'($urandom);
      io.flush_valid       = 1'b1;
      #1;
      if (io.read_ready || io.write_ready || io.flush_ready) bad = 1'b1;
      @(posedge clock);
      #1;
      n++;
    end
    io.read_valid  = 1'b0;
    io.write_valid = 1'b0;
    io.flush_valid = 1'b0;
    check(nm, 256'(n), 256'(NSETS));
    check("sweep_ready_zero", 256'(bad), 256'(0));
    in_run = 1'b1;
  endtask

  task automatic drive(bit rv, int ridx, bit wv, int widx, logic [NWAYS-1:0] wm,
                       logic [COH_BITS-1:0] coh, logic [TAG_BITS-1:0] tag, bit fv);
    bit rf, wf, ff;
    @(negedge clock);
    io.read_valid = rv;
    io.read_bits_idx = IDX_W'(ridx);
    io.write_valid = wv;
    io.write_bits_idx = IDX_W'(widx);
    io.write_bits_way_en = wm;
    io.write_bits_data_coh_state = coh;
    io.write_bits_data_tag = tag;
    io.flush_valid = fv;
    #1;
    check("read_ready", 256'(io.read_ready), 256'(in_run && !wv));
    check("write_ready", 256'(io.write_ready), 256'(in_run));
    check("flush_ready", 256'(io.flush_ready), 256'(in_run && !wv));
    rf = rv && in_run && !wv;
    wf = wv && in_run;
    ff = fv && in_run && !wv;
    if (rf) q.push_back(model_row(ridx, cyc + 1));
    if (wf)
      for (int w = 0; w < NWAYS; w++)
        if (wm[w]) begin
          m_coh[widx][w] = coh;
          m_tag[widx][w] = tag;
        end
    if (ff) begin
      model_zero();
      in_run = 1'b0;
      @(posedge clock);
      #1;
      wait_init("flush_sweep_cycles");
    end
  endtask

  task automatic rd(int idx);
    drive(1'b1, idx, 1'b0, 0, '0, '0, '0, 1'b0);
  endtask

  task automatic wr(int idx, logic [NWAYS-1:0] wm, logic [COH_BITS-1:0] coh, logic [TAG_BITS-1:0] tag);
    drive(1'b0, 0, 1'b1, idx, wm, coh, tag, 1'b0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    io.read_valid = 1'b0;
    io.read_bits_idx = '0;
    io.write_valid = 1'b0;
    io.write_bits_idx = '0;
    io.write_bits_way_en = '0;
    io.write_bits_data_coh_state = '0;
    io.write_bits_data_tag = '0;
    io.flush_valid = 1'b0;
    model_zero();
    repeat (3) @(posedge clock);
    #1;
    mon_en = 1'b1;
    check("reset_init_done", 256'(io.init_done), 256'(0));
    check("reset_resp_valid", 256'(io.resp_valid), 256'(0));
    @(negedge clock);
    reset_n = 1'b1;
    wait_init("reset_sweep_cycles");

    for (int s = 0; s < NSETS; s++) rd(s);

    // Single-way write then immediate read.
    wr(5, 8'h04, 2'd3, 21'h1ABCD);
    rd(5);
    // way_en of zero changes nothing.
    wr(5, 8'h00, 2'd1, 21'h00FFF);
    rd(5);

    // Read issued once, then idle: data must hold.
    wr(7, 8'hFF, 2'd2, 21'h13579);
    rd(7);
    idle(4);

    // Simultaneous read+write for 3 cycles: writes win, read fires on the 4th.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 21, 1'b1, 20 + i, 8'h81, 2'(i + 1), TAG_BITS'(32'h100 + i), 1'b0);
    rd(21);
    rd(20);
    rd(22);

    // Fill every set, then flush with a read in the same cycle.
    for (int s = 0; s < NSETS; s++)
      wr(s, '1, 2'($urandom_range(1, 3)), TAG_BITS'($urandom_range(1, 32'h1FFFFF)));
    rd(33);
    drive(1'b1, 63, 1'b0, 0, '0, '0, '0, 1'b1);
    for (int s = 0; s < NSETS; s++) rd(s);

    // Randomised traffic with occasional flush.
    for (int i = 0; i < 500; i++) begin
      int ridx;
      int widx;
      ridx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NSETS-1) : $urandom_range(0, 7);
      widx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NSETS-1) : $urandom_range(0, 7);
      drive(1'($urandom_range(0, 1)), ridx, ($urandom_range(0, 2) == 0), widx,
            NWAYS'($urandom), COH_BITS'($urandom), TAG_BITS'($urandom),
            ($urandom_range(0, 199) == 0));
    end
    idle(3);

    // Reset asserted for one cycle with the sweep counter at 30.
    @(negedge clock);
    reset_n = 1'b0;
    last_coh = '0;
    last_tag = '0;
    in_run = 1'b0;
    model_zero();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (30) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    wait_init("reset_midsweep_cycles");
    for (int s = 0; s < 8; s++) rd(s * 9);
    idle(4);

    check("queue_drained", 256'(q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
